// File: rtl/serial_magnitude_comp_pkg.sv
// Shared types and default sizing for the serial magnitude comparator.
package serial_magnitude_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SLICE = 2;

    // Index width for a given slice count, never narrower than one bit.
    function automatic int idx_width(input int n_slices);
        return (n_slices > 1) ? $clog2(n_slices) : 1;
    endfunction

endpackage

// File: rtl/serial_magnitude_comp_cmp_slice.sv
// Combinational unsigned compare of one SLICE-bit operand slice.
module cmp_slice #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             eq,
    output logic             gt
);

    always_comb begin
        eq = (a == b);
        gt = (a > b);
    end

endmodule

// File: rtl/serial_magnitude_comp.sv
// MSB-first serial magnitude comparator, SLICE bits per cycle with early exit.
module serial_magnitude_comp
    import serial_magnitude_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Eq,
    output logic             Gt,
    output logic             Lt
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = idx_width(NSLICE);

    if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
        $error("serial_magnitude_comp: WIDTH must be a non-zero multiple of SLICE");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sm_q, sm_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic             s_eq;
    logic             s_gt;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        a_cmp   = a_q ^ (WIDTH'(sm_q) << (WIDTH - 1));
        b_cmp   = b_q ^ (WIDTH'(sm_q) << (WIDTH - 1));
        a_slice = a_cmp[int'(idx_q) * SLICE +: SLICE];
        b_slice = b_cmp[int'(idx_q) * SLICE +: SLICE];
    end

    cmp_slice #(
        .SLICE (SLICE)
    ) u_cmp_slice (
        .a  (a_slice),
        .b  (b_slice),
        .eq (s_eq),
        .gt (s_gt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = IDX_W'(NSLICE - 1);
                    a_d     = A;
                    b_d     = B;
                    sm_d    = signed_mode;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!s_eq) begin
                    state_d = DONE;
                    gt_d    = s_gt;
                    lt_d    = !s_gt;
                end else if (idx_q == '0) begin
                    state_d = DONE;
                    eq_d    = 1'b1;
                end
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        Eq   = eq_q;
        Gt   = gt_q;
        Lt   = lt_q;
    end

endmodule

// File: tb/tb_serial_magnitude_comp.sv
// Scoreboard bench for serial_magnitude_comp at WIDTH=8, SLICE=2.
module tb_serial_magnitude_comp;

    localparam int WIDTH = 8;
    localparam int SLICE = 2;

    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             Eq;
    logic             Gt;
    logic             Lt;

    typedef struct {
        logic [2:0] flags;
        int         acc;
        int         lat;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc;
    int         n_vec;
    int         n_fail;
    logic [2:0] last_flags;

    serial_magnitude_comp #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Eq          (Eq),
        .Gt          (Gt),
        .Lt          (Lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, checks flags between pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_flags = '0;
        end else if (done) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_flags", {29'd0, Eq, Gt, Lt}, {29'd0, e.flags});
                check("latency", cyc - e.acc, e.lat);
                last_flags = {Eq, Gt, Lt};
            end
        end else if (busy) begin
            check("flags_clear_while_busy", {29'd0, Eq, Gt, Lt}, 32'd0);
        end else begin
            check("flags_hold", {29'd0, Eq, Gt, Lt}, {29'd0, last_flags});
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input logic [2:0] flags, input int lat, input bit expect_done);
        @(negedge clk);
        A           = a;
        B           = b;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk);
        #1;
        if (expect_done) sb_q.push_back('{flags, cyc, lat});
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("completion_timeout", {31'd0, n >= 40}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {27'd0, busy, done, Eq, Gt, Lt}, 32'd0);
    endtask

    initial begin
        int c;
        n_vec       = 0;
        n_fail      = 0;
        last_flags  = '0;
        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        A           = '0;
        B           = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        #3 rst_n = 1'b1;

        // Full-length equal compare, then early exits.
        issue(8'hA5, 8'hA5, 1'b0, F_EQ, 4, 1'b1); wait_idle();
        issue(8'hC0, 8'h3F, 1'b0, F_GT, 1, 1'b1); wait_idle();
        issue(8'h80, 8'h01, 1'b1, F_LT, 1, 1'b1); wait_idle();
        issue(8'h80, 8'h01, 1'b0, F_GT, 1, 1'b1); wait_idle();
        issue(8'hFF, 8'hFE, 1'b1, F_GT, 4, 1'b1); wait_idle();
        issue(8'h7F, 8'h80, 1'b1, F_GT, 1, 1'b1); wait_idle();
        issue(8'hF0, 8'hF4, 1'b1, F_LT, 3, 1'b1); wait_idle();

        // Start pulse mid-run with different operands must be ignored.
        issue(8'h12, 8'h13, 1'b0, F_LT, 4, 1'b1);
        @(negedge clk);
        A = 8'hFF; B = 8'h00; signed_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // Reset during the second RUN cycle abandons the compare.
        issue(8'h21, 8'h22, 1'b0, F_LT, 4, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset_mid_run");
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(8'h01, 8'h00, 1'b0, F_GT, 4, 1'b1); wait_idle();

        // Start held through DONE: second compare accepted on the DONE edge.
        @(negedge clk);
        A = 8'h55; B = 8'h55; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        c = cyc;
        sb_q.push_back('{F_EQ, c, 4});
        sb_q.push_back('{F_LT, c + 5, 1});
        A = 8'h40; B = 8'h80;
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
